// File: rtl/muldiv_if.sv
// Command/result bundle between the decode stage and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: the unit raises stall while busy. The decode side holds the command until stall drops.
interface muldiv_if;
    logic        muldiv_en;
    logic [2:0]  MulDivFunct;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        flush;
    logic        busy;
    logic        stall;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output muldiv_en, MulDivFunct, rs_value, rt_value, flush,
        input  busy, stall, result, hi, lo
    );

    modport slave (
        input  muldiv_en, MulDivFunct, rs_value, rt_value, flush,
        output busy, stall, result, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit mult/multu/div/divu unit with architectural HI/LO registers and move commands.
// Latency: mul/div write HI/LO after 33 busy cycles. Moves take one cycle. Define MULDIV_FAST_MULT_EN to get single-cycle multiply.
// Backpressure: stall = muldiv_en & busy. Flush or reset abandons the operation in flight without writing HI/LO.
module muldiv_unit (
    input  logic     clk,
    input  logic     nreset,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] mag_a, mag_b;
    logic        neg_a, neg_b, op_div;
    logic [63:0] work;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;

    // Operand magnitudes and signs. Unsigned commands (odd codes) never count as negative.
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;
    assign rs_neg = ~bus.MulDivFunct[0] & bus.rs_value[31];
    assign rt_neg = ~bus.MulDivFunct[0] & bus.rt_value[31];
    assign rs_mag = rs_neg ? -bus.rs_value : bus.rs_value;
    assign rt_mag = rt_neg ? -bus.rt_value : bus.rt_value;

    // work holds {partial_product_hi, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [32:0] mul_sum, div_shift, div_diff;
    assign mul_sum   = {1'b0, work[63:32]} + {1'b0, (work[0] ? mag_a : 32'd0)};
    assign div_shift = {work[63:32], work[31]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, dividend;
    assign prod_fix = (neg_a ^ neg_b) ? -work : work;
    assign quo_fix  = (neg_a ^ neg_b) ? -work[31:0] : work[31:0];
    assign rem_fix  = neg_a ? -work[63:32] : work[63:32];
    assign dividend = neg_a ? -mag_a : mag_a;

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_mag, fast_prod;
    assign fast_mag  = {32'd0, rs_mag} * {32'd0, rt_mag};
    assign fast_prod = (rs_neg ^ rt_neg) ? -fast_mag : fast_mag;
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            op_div <= 1'b0;
            work   <= 64'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
        end else if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.muldiv_en) begin
                    case (bus.MulDivFunct)
                        3'b000, 3'b001: begin
`ifdef MULDIV_FAST_MULT_EN
                            hi_q <= fast_prod[63:32];
                            lo_q <= fast_prod[31:0];
`else
                            mag_a  <= rs_mag;
                            mag_b  <= rt_mag;
                            neg_a  <= rs_neg;
                            neg_b  <= rt_neg;
                            op_div <= 1'b0;
                            cnt    <= 5'd0;
                            work   <= {32'd0, rt_mag};
                            busy_q <= 1'b1;
                            state  <= MUL;
`endif
                        end
                        3'b010, 3'b011: begin
                            mag_a  <= rs_mag;
                            mag_b  <= rt_mag;
                            neg_a  <= rs_neg;
                            neg_b  <= rt_neg;
                            op_div <= 1'b1;
                            cnt    <= 5'd0;
                            work   <= {32'd0, rs_mag};
                            busy_q <= 1'b1;
                            state  <= DIV;
                        end
                        3'b110:  lo_q <= bus.rs_value;
                        3'b111:  hi_q <= bus.rs_value;
                        default: ;
                    endcase
                end
                MUL: begin
                    work <= {mul_sum, work[31:1]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                DIV: begin
                    if (!div_diff[32]) work <= {div_diff[31:0], work[30:0], 1'b1};
                    else               work <= {div_shift[31:0], work[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (!op_div) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (mag_b == 32'd0) begin
                        hi_q <= dividend;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = nreset & busy_q;
    assign bus.stall  = nreset & bus.muldiv_en & busy_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.result = (!nreset || !bus.muldiv_en || busy_q) ? 32'd0 :
                        (bus.MulDivFunct == 3'b100) ? lo_q :
                        (bus.MulDivFunct == 3'b101) ? hi_q : 32'd0;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an arithmetic reference model checked every cycle, plus hand-computed literal results.
// Honours MULDIV_FAST_MULT_EN for the multiply timing.
module tb_muldiv_unit;
    localparam bit [2:0] F_MULT = 3'd0, F_MULTU = 3'd1, F_DIV = 3'd2, F_DIVU = 3'd3;
    localparam bit [2:0] F_MFLO = 3'd4, F_MFHI = 3'd5, F_MTLO = 3'd6, F_MTHI = 3'd7;

    logic clk = 1'b0;
    logic nreset;
    muldiv_if bus();

    muldiv_unit dut (.clk(clk), .nreset(nreset), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain arithmetic on whole operands.
    function automatic logic [63:0] mul_ref(input bit [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (f == F_MULT) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [63:0] div_ref(input bit [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (f == F_DIV) begin
            sa = $signed(a);
            sb = $signed(b);
            q = sa / sb;
            r = sa % sb;
            qv = 64'(q);
            rv = 64'(r);
            return {rv[31:0], qv[31:0]};
        end
        return {a % b, a / b};
    endfunction

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi, m_plo;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] e_res;
    logic [63:0] r64;

    always @(negedge clk) begin
        e_res = 32'd0;
        if (nreset && bus.muldiv_en && !m_busy)
            e_res = (bus.MulDivFunct == F_MFLO) ? m_lo : (bus.MulDivFunct == F_MFHI) ? m_hi : 32'd0;
        check("cyc_busy",   {31'd0, bus.busy},  {31'd0, nreset & m_busy});
        check("cyc_stall",  {31'd0, bus.stall}, {31'd0, nreset & m_busy & bus.muldiv_en});
        check("cyc_result", bus.result, e_res);
        check("cyc_hi",     bus.hi, m_hi);
        check("cyc_lo",     bus.lo, m_lo);
        if (!nreset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0;
        end else if (bus.flush) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi; m_lo = m_plo; m_busy = 1'b0;
            end
        end else if (bus.muldiv_en) begin
            case (bus.MulDivFunct)
                F_MULT, F_MULTU: begin
                    r64 = mul_ref(bus.MulDivFunct, bus.rs_value, bus.rt_value);
`ifdef MULDIV_FAST_MULT_EN
                    m_hi = r64[63:32]; m_lo = r64[31:0];
`else
                    m_phi = r64[63:32]; m_plo = r64[31:0]; m_busy = 1'b1; m_left = 33;
`endif
                end
                F_DIV, F_DIVU: begin
                    r64 = div_ref(bus.MulDivFunct, bus.rs_value, bus.rt_value);
                    m_phi = r64[63:32]; m_plo = r64[31:0]; m_busy = 1'b1; m_left = 33;
                end
                F_MTLO:  m_lo = bus.rs_value;
                F_MTHI:  m_hi = bus.rs_value;
                default: ;
            endcase
        end
    end

    task automatic set_in(input bit en, input bit [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit fl, input bit rn);
        bus.muldiv_en   = en;
        bus.MulDivFunct = f;
        bus.rs_value    = a;
        bus.rt_value    = b;
        bus.flush       = fl;
        nreset          = rn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        set_in(1'b0, F_MFLO, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy === 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("idle_wait", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(input bit [2:0] f, input logic [31:0] a, input logic [31:0] b);
        set_in(1'b1, f, a, b, 1'b0, 1'b1);
        step();
        idle_in();
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_in(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) step();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_result", bus.result, 32'd0);
        idle_in();
        step();

        // Moves, and a combinational mfhi read.
        run_op(F_MTLO, 32'd6, 32'd0);
        run_op(F_MTHI, 32'd5, 32'd0);
        check("mt_lo", bus.lo, 32'd6);
        check("mt_hi", bus.hi, 32'd5);
        set_in(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b1);
        #1 check("mfhi_comb", bus.result, 32'd5);
        step();

        // multu FFFFFFFF*2, with the busy window measured from the accept cycle N.
        set_in(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        step();
        idle_in();
`ifdef MULDIV_FAST_MULT_EN
        check("multu_busy_n1", {31'd0, bus.busy}, 32'd0);
`else
        check("multu_busy_n1", {31'd0, bus.busy}, 32'd1);
        repeat (32) step();
        check("multu_busy_n33", {31'd0, bus.busy}, 32'd1);
        step();
        check("multu_busy_n34", {31'd0, bus.busy}, 32'd0);
`endif
        check("multu_hi", bus.hi, 32'd1);
        check("multu_lo", bus.lo, 32'hFFFF_FFFE);

        run_op(F_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);
        run_op(F_MULT, 32'h8000_0000, 32'd1);
        check("mult_min_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_min_lo", bus.lo, 32'h8000_0000);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(F_DIV, 32'd7, 32'hFFFF_FFFE);
        check("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_negb_hi", bus.hi, 32'd1);
        run_op(F_DIVU, 32'd7, 32'd0);
        check("divu_z_lo", bus.lo, 32'hFFFF_FFFF);
        check("divu_z_hi", bus.hi, 32'd7);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd0);
        check("div_z_lo", bus.lo, 32'hFFFF_FFFF);
        check("div_z_hi", bus.hi, 32'hFFFF_FFF9);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        check("div_ovf_hi", bus.hi, 32'd0);
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd10);
        check("divu_lo", bus.lo, 32'h1999_9999);
        check("divu_hi", bus.hi, 32'd5);
        run_op(F_DIV, 32'hFFFF_FFFF, 32'd10);
        check("div_small_lo", bus.lo, 32'd0);
        check("div_small_hi", bus.hi, 32'hFFFF_FFFF);

        // mflo issued in N+5 of a divide stalls through N+33 and is accepted in N+34.
        set_in(1'b1, F_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
        step();
        idle_in();
        repeat (4) step();
        set_in(1'b1, F_MFLO, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 5; k <= 33; k++) begin
            #1 check("mflo_stall", {31'd0, bus.stall}, 32'd1);
            step();
        end
        #1 check("mflo_stall_n34", {31'd0, bus.stall}, 32'd0);
        check("mflo_result", bus.result, 32'd14);
        step();
        idle_in();

        // Flush in N+10 of a mult.
        run_op(F_MTHI, 32'd5, 32'd0);
        run_op(F_MTLO, 32'd6, 32'd0);
        set_in(1'b1, F_MULTU, 32'd3, 32'd4, 1'b0, 1'b1);
        step();
        idle_in();
        repeat (9) step();
        set_in(1'b0, F_MFLO, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        idle_in();
        check("flush_busy_n11", {31'd0, bus.busy}, 32'd0);
        step();
        check("flush_busy_n12", {31'd0, bus.busy}, 32'd0);
`ifdef MULDIV_FAST_MULT_EN
        check("flush_hi", bus.hi, 32'd0);
        check("flush_lo", bus.lo, 32'd12);
`else
        check("flush_hi", bus.hi, 32'd5);
        check("flush_lo", bus.lo, 32'd6);
`endif

        // Same with reset in N+10 instead of flush.
        set_in(1'b1, F_MULTU, 32'd3, 32'd4, 1'b0, 1'b1);
        step();
        idle_in();
        repeat (9) step();
        set_in(1'b0, F_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        idle_in();
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        run_op(F_MTLO, 32'hA5A5_0001, 32'd0);
        check("rst_mid_idle", bus.lo, 32'hA5A5_0001);

        // mthi with and without flush. A mult presented with flush is discarded.
        set_in(1'b1, F_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b1);
        step();
        idle_in();
        check("mthi_flush", bus.hi, 32'd0);
        run_op(F_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        set_in(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b1);
        #1 check("mfhi_result", bus.result, 32'h1234_5678);
        step();
        set_in(1'b1, F_MULT, 32'd9, 32'd9, 1'b1, 1'b1);
        step();
        idle_in();
        check("mult_flush_busy", {31'd0, bus.busy}, 32'd0);
        check("mult_flush_lo", bus.lo, 32'hA5A5_0001);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
